instr_adder_sequencer: RTL and testbench

Host-side driver for the instrumented Kogge-Stone adder: accepts a measurement command (operands plus repetition count), drives the operands and run strobe into the adder, waits for each run to finish, and collects the adder's delay count. Over the repetitions it accumulates the count sum and maximum and checks each adder sum against the expected value. Sits between the logic-analyzer/Wishbone register front end and the adder's operand, run and result port, replacing manual LA bit-banging.

---
 rtl/instr_seq_pkg.sv | 25 ++
 rtl/instr_seq_accum.sv | 64 ++++++
 rtl/instr_adder_sequencer.sv | 159 +++++++++++++++
 tb/tb_instr_adder_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared types and widths for the instrumented-adder measurement sequencer.
package instr_seq_pkg;

    localparam int DATA_W = 32;
    localparam int SUM_W  = 40;
    localparam int REP_W  = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN,
        ST_CAPTURE,
        ST_DRAIN,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [SUM_W-1:0]  count_sum;
        logic [DATA_W-1:0] count_max;
        logic [REP_W-1:0]  errors;
        logic              timeout;
        logic [REP_W-1:0]  done_reps;
    } rsp_t;

endpackage

// File: rtl/instr_seq_accum.sv
// Per-command accumulators: count sum, count maximum, sum-error tally and completed repetitions.
module instr_seq_accum
    import instr_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              capture_i,
    input  logic [DATA_W-1:0] count_i,
    input  logic [DATA_W-1:0] sum_i,
    input  logic [DATA_W-1:0] expected_i,
    output logic [SUM_W-1:0]  count_sum_o,
    output logic [DATA_W-1:0] count_max_o,
    output logic [REP_W-1:0]  errors_o,
    output logic [REP_W-1:0]  done_reps_o
);

    logic [SUM_W-1:0]  count_sum_q, count_sum_d;
    logic [DATA_W-1:0] count_max_q, count_max_d;
    logic [REP_W-1:0]  errors_q, errors_d;
    logic [REP_W-1:0]  done_reps_q, done_reps_d;

    always_comb begin
        count_sum_d = count_sum_q;
        count_max_d = count_max_q;
        errors_d    = errors_q;
        done_reps_d = done_reps_q;
        if (clear_i) begin
            count_sum_d = '0;
            count_max_d = '0;
            errors_d    = '0;
            done_reps_d = '0;
        end else if (capture_i) begin
            count_sum_d = count_sum_q + {{(SUM_W-DATA_W){1'b0}}, count_i};
            if (count_i > count_max_q) begin
                count_max_d = count_i;
            end
            if (sum_i != expected_i) begin
                errors_d = errors_q + REP_W'(1);
            end
            done_reps_d = done_reps_q + REP_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_sum_q <= '0;
            count_max_q <= '0;
            errors_q    <= '0;
            done_reps_q <= '0;
        end else begin
            count_sum_q <= count_sum_d;
            count_max_q <= count_max_d;
            errors_q    <= errors_d;
            done_reps_q <= done_reps_d;
        end
    end

    assign count_sum_o = count_sum_q;
    assign count_max_o = count_max_q;
    assign errors_o    = errors_q;
    assign done_reps_o = done_reps_q;

endmodule

// File: rtl/instr_adder_sequencer.sv
// Drives repeated measurement runs of the instrumented adder and reports
// accumulated delay counts, sum errors and timeout status per command.
module instr_adder_sequencer
    import instr_seq_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [7:0]        cmd_reps,
    output logic [DATA_W-1:0] adder_a,
    output logic [DATA_W-1:0] adder_b,
    output logic              adder_run,
    input  logic              adder_done,
    input  logic [DATA_W-1:0] adder_count,
    input  logic [DATA_W-1:0] adder_sum,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [SUM_W-1:0]  rsp_count_sum,
    output logic [DATA_W-1:0] rsp_count_max,
    output logic [REP_W-1:0]  rsp_errors,
    output logic              rsp_timeout,
    output logic [REP_W-1:0]  rsp_done_reps
);

    localparam int SET_W = (SETTLE  > 1) ? $clog2(SETTLE)  : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, exp_q, exp_d;
    logic [REP_W-1:0]  reps_q, reps_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              timeout_q, timeout_d;
    logic              acc_clear, acc_capture;
    rsp_t              rsp;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        exp_d        = exp_q;
        reps_d       = reps_q;
        settle_cnt_d = settle_cnt_q;
        to_cnt_d     = to_cnt_q;
        timeout_d    = timeout_q;
        acc_clear    = 1'b0;
        acc_capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    a_d          = cmd_a;
                    b_d          = cmd_b;
                    exp_d        = cmd_a + cmd_b;
                    reps_d       = (cmd_reps == 8'd0) ? REP_W'(256) : REP_W'(cmd_reps);
                    timeout_d    = 1'b0;
                    settle_cnt_d = '0;
                    acc_clear    = 1'b1;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SET_W'(SETTLE - 1)) begin
                    to_cnt_d = '0;
                    state_d  = ST_RUN;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            ST_RUN: begin
                // A done arriving on the timeout cycle still counts as a completed run.
                if (adder_done) begin
                    state_d = ST_CAPTURE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_CAPTURE: begin
                acc_capture = 1'b1;
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!adder_done) begin
                    if (rsp.done_reps == reps_q || timeout_q) begin
                        state_d = ST_RESP;
                    end else begin
                        settle_cnt_d = '0;
                        state_d      = ST_SETTLE;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            exp_q        <= '0;
            reps_q       <= '0;
            settle_cnt_q <= '0;
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            exp_q        <= exp_d;
            reps_q       <= reps_d;
            settle_cnt_q <= settle_cnt_d;
            to_cnt_q     <= to_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    instr_seq_accum u_accum (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .clear_i     (acc_clear),
        .capture_i   (acc_capture),
        .count_i     (adder_count),
        .sum_i       (adder_sum),
        .expected_i  (exp_q),
        .count_sum_o (rsp.count_sum),
        .count_max_o (rsp.count_max),
        .errors_o    (rsp.errors),
        .done_reps_o (rsp.done_reps)
    );

    assign rsp.timeout = timeout_q;

    // Run is decoded from state so an asynchronous reset drops it immediately.
    assign adder_run     = (state_q == ST_RUN) || (state_q == ST_CAPTURE);
    assign cmd_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = (state_q == ST_RESP);
    assign adder_a       = a_q;
    assign adder_b       = b_q;
    assign rsp_count_sum = rsp.count_sum;
    assign rsp_count_max = rsp.count_max;
    assign rsp_errors    = rsp.errors;
    assign rsp_timeout   = rsp.timeout;
    assign rsp_done_reps = rsp.done_reps;

endmodule

// File: tb/tb_instr_adder_sequencer.sv
// Scoreboard bench for instr_adder_sequencer with a behavioural adder and reference model.
module tb_instr_adder_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [7:0]  cmd_reps;
    logic [31:0] adder_a, adder_b, adder_count, adder_sum;
    logic        adder_run, adder_done;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [39:0] rsp_count_sum;
    logic [31:0] rsp_count_max;
    logic [8:0]  rsp_errors, rsp_done_reps;

    always #5 wb_clk_i = ~wb_clk_i;

    instr_adder_sequencer #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_reps      (cmd_reps),
        .adder_a       (adder_a),
        .adder_b       (adder_b),
        .adder_run     (adder_run),
        .adder_done    (adder_done),
        .adder_count   (adder_count),
        .adder_sum     (adder_sum),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_count_sum (rsp_count_sum),
        .rsp_count_max (rsp_count_max),
        .rsp_errors    (rsp_errors),
        .rsp_timeout   (rsp_timeout),
        .rsp_done_reps (rsp_done_reps)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          lat;   // negative: adder never answers
        logic [31:0] cnt;
        logic [31:0] sum;
    } run_t;

    typedef struct {
        logic [39:0] csum;
        logic [31:0] cmax;
        logic [8:0]  err;
        logic        to;
        logic [8:0]  reps;
    } exp_t;

    run_t        run_q[$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          run_rises = 0;
    bit          hold_ready = 1'b0;
    int          plan_lat[256];
    logic [31:0] plan_cnt[256];
    logic [31:0] plan_sum[256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    // Behavioural adder: answers each run after its planned latency, holds done until run falls.
    initial begin : adder_model
        run_t e;
        int   n;
        bit   aborted;
        adder_done  = 1'b0;
        adder_count = '0;
        adder_sum   = '0;
        forever begin
            @(posedge wb_clk_i); #1;
            if (adder_run) begin
                run_rises++;
                if (run_q.size() == 0) begin
                    chk("run_unexpected", 64'd1, 64'd0);
                    n = 0;
                    while (adder_run && n < 4096) begin @(posedge wb_clk_i); #1; n++; end
                end else begin
                    e = run_q.pop_front();
                    chk("adder_a", adder_a, e.a);
                    chk("adder_b", adder_b, e.b);
                    if (e.lat < 0) begin
                        n = 1;
                        forever begin
                            @(posedge wb_clk_i); #1;
                            if (!adder_run || n > 4096) break;
                            n++;
                        end
                        chk("timeout_run_cycles", n, TIMEOUT);
                    end else begin
                        aborted = 1'b0;
                        for (int i = 0; i < e.lat; i++) begin
                            @(posedge wb_clk_i); #1;
                            if (!adder_run) begin aborted = 1'b1; break; end
                        end
                        if (!aborted) begin
                            adder_done  = 1'b1;
                            adder_count = e.cnt;
                            adder_sum   = e.sum;
                            n = 0;
                            while (adder_run && n < 4096) begin @(posedge wb_clk_i); #1; n++; end
                            repeat ($urandom_range(0, 2)) begin @(posedge wb_clk_i); #1; end
                            adder_done  = 1'b0;
                            adder_count = $urandom;
                            adder_sum   = $urandom;
                        end
                    end
                end
            end
        end
    end

    initial begin : ready_driver
        rsp_ready = 1'b0;
        forever begin
            @(posedge wb_clk_i); #1;
            rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        exp_t ex;
        forever begin
            @(negedge wb_clk_i);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    ex = exp_q.pop_front();
                    chk("rsp_count_sum", rsp_count_sum, ex.csum);
                    chk("rsp_count_max", rsp_count_max, ex.cmax);
                    chk("rsp_errors", rsp_errors, ex.err);
                    chk("rsp_timeout", rsp_timeout, ex.to);
                    chk("rsp_done_reps", rsp_done_reps, ex.reps);
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog actual=hung expected=finish");
        $fatal(1, "simulation did not finish");
    end

    // Reference model: response derived directly from the planned per-run results.
    task automatic do_cmd(input logic [31:0] a, input logic [31:0] b, input logic [7:0] reps,
                          input bit to_mode, input bit expect_rsp);
        exp_t        ex;
        run_t        r;
        int          n;
        logic [31:0] good;
        good = a + b;
        n    = (reps == 8'd0) ? 256 : int'(reps);
        ex   = '{40'd0, 32'd0, 9'd0, 1'b0, 9'd0};
        if (to_mode) begin
            r = '{a, b, -1, 32'd0, 32'd0};
            run_q.push_back(r);
            ex.to = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                r = '{a, b, plan_lat[i], plan_cnt[i], plan_sum[i]};
                run_q.push_back(r);
                ex.csum = ex.csum + {8'd0, plan_cnt[i]};
                if (plan_cnt[i] > ex.cmax) ex.cmax = plan_cnt[i];
                if (plan_sum[i] != good) ex.err = ex.err + 9'd1;
                ex.reps = ex.reps + 9'd1;
            end
        end
        if (expect_rsp) exp_q.push_back(ex);
        cmd_a = a; cmd_b = b; cmd_reps = reps; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20000) begin @(posedge wb_clk_i); #1; n++; end
        if (!cmd_ready) chk("cmd_accept_wait", 64'd0, 64'd1);
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b0;
        cmd_a = $urandom; cmd_b = $urandom; cmd_reps = 8'($urandom);
        chk("cmd_ready_busy", cmd_ready, 64'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 20000) begin @(posedge wb_clk_i); #1; n++; end
        if (n >= 20000) chk("idle_wait", 64'd0, 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 64'd1);
        chk({tag, "_adder_run"}, adder_run, 64'd0);
        chk({tag, "_rsp_valid"}, rsp_valid, 64'd0);
        chk({tag, "_adder_a"}, adder_a, 64'd0);
        chk({tag, "_adder_b"}, adder_b, 64'd0);
        chk({tag, "_rsp_count_sum"}, rsp_count_sum, 64'd0);
        chk({tag, "_rsp_count_max"}, rsp_count_max, 64'd0);
        chk({tag, "_rsp_errors"}, rsp_errors, 64'd0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 64'd0);
        chk({tag, "_rsp_done_reps"}, rsp_done_reps, 64'd0);
    endtask

    initial begin : stimulus
        int          base;
        int          n;
        logic [31:0] a, b;
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_reps  = '0;
        repeat (3) @(negedge wb_clk_i);
        check_all_zero("reset");
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        plan_lat[0] = 10; plan_cnt[0] = 100; plan_sum[0] = 8;
        do_cmd(32'd3, 32'd5, 8'd1, 1'b0, 1'b1);
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            plan_lat[i] = $urandom_range(1, 8);
            plan_sum[i] = 8;
        end
        plan_cnt[0] = 10; plan_cnt[1] = 40; plan_cnt[2] = 20; plan_cnt[3] = 30;
        base = run_rises;
        do_cmd(32'd3, 32'd5, 8'd4, 1'b0, 1'b1);
        wait_idle();
        chk("run_pulses_reps4", run_rises - base, 64'd4);

        a = $urandom; b = $urandom;
        for (int i = 0; i < 256; i++) begin
            plan_lat[i] = $urandom_range(1, 3);
            plan_cnt[i] = 32'hFFFF_FFFF;
            plan_sum[i] = a + b;
        end
        do_cmd(a, b, 8'd0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            plan_lat[i] = $urandom_range(1, 6);
            plan_cnt[i] = $urandom_range(1, 1000);
            plan_sum[i] = (i == 1) ? 32'd7 : 32'd8;
        end
        do_cmd(32'd3, 32'd5, 8'd3, 1'b0, 1'b1);

        do_cmd($urandom, $urandom, 8'd2, 1'b1, 1'b1);
        wait_idle();

        for (int k = 0; k < 9; k++) begin
            a = $urandom; b = $urandom;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                plan_lat[i] = $urandom_range(1, 12);
                plan_cnt[i] = $urandom;
                plan_sum[i] = ($urandom_range(0, 3) == 0) ? a + b + 32'd1 : a + b;
            end
            do_cmd(a, b, 8'(n), 1'b0, 1'b1);
        end
        wait_idle();

        hold_ready = 1'b1;
        @(posedge wb_clk_i); #1;
        a = $urandom; b = $urandom;
        plan_lat[0] = 2;  plan_cnt[0] = 77; plan_sum[0] = a + b;
        plan_lat[1] = 12; plan_cnt[1] = 99; plan_sum[1] = a + b;
        plan_lat[2] = 2;  plan_cnt[2] = 55; plan_sum[2] = a + b;
        base = run_rises;
        do_cmd(a, b, 8'd3, 1'b0, 1'b0);
        n = 0;
        while (run_rises < base + 2 && n < 2000) begin @(posedge wb_clk_i); #1; n++; end
        chk("reset_reached_second_run", run_rises - base, 64'd2);
        repeat (2) @(posedge wb_clk_i);
        #3;
        wb_rst_i = 1'b1;
        #1;
        chk("async_rst_adder_run", adder_run, 64'd0);
        chk("async_rst_cmd_ready", cmd_ready, 64'd1);
        chk("async_rst_rsp_valid", rsp_valid, 64'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check_all_zero("post_reset");
        run_q.delete();
        hold_ready = 1'b0;
        @(posedge wb_clk_i); #1;

        plan_lat[0] = 5; plan_cnt[0] = 1234; plan_sum[0] = 32'd30;
        plan_lat[1] = 3; plan_cnt[1] = 4321; plan_sum[1] = 32'd31;
        do_cmd(32'd10, 32'd20, 8'd2, 1'b0, 1'b1);
        wait_idle();
        chk("run_queue_drained", run_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
